// File: rtl/wshb_arb_pkg.sv
// Shared definitions for the two-master Wishbone classic arbiter.
//
// Contents:
//   arb_state_t     grant FSM states (IDLE, GNT0, GNT1, GAP)
//   GNT_*           one-hot grant encodings (bit0 = master 0, bit1 = master 1)
//   CTI_W / BTE_W   widths of the Wishbone cycle-type and burst-type fields
//   state_to_grant  maps an FSM state onto its one-hot grant vector
//
// Optional build macro used by the arbiter: WSHB_ARB_RR_EN (round-robin ties).
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

  function automatic logic [1:0] state_to_grant(input arb_state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      GNT0:    g = GNT_M0;
      GNT1:    g = GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wshb_arb_fsm.sv
// Grant FSM for the two-master Wishbone arbiter.
//
// Holds the grant state, the per-grant hold counter used for bounded-hold
// preemption, and the last-owner register.  Produces the one-hot grant vector
// consumed by the muxing in the top level.
//
// Ports:
//   clk_i      Wishbone clock
//   rst_i      synchronous, active-high reset
//   m0_cyc_i   master 0 (video reader) bus request
//   m1_cyc_i   master 1 (writer) bus request
//   s_ack_i    slave acknowledge
//   grant_o    one-hot current owner, 00 when idle, in the gap or in reset
//
// Parameters:
//   MAX_HOLD   acks one owner may take while the other master requests;
//              0 disables preemption.
//
// Build macro: WSHB_ARB_RR_EN selects round-robin tie breaking; when it is
// undefined master 0 wins every tie.
module wshb_arb_fsm
  import wshb_arb_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic       m1_cyc_i,
  input  logic       s_ack_i,
  output logic [1:0] grant_o
);

  // A zero-width counter is illegal, so keep one bit when preemption is off.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_m1_q, last_m1_d;  // 1: master 1 owned the last grant

  arb_state_t pick_state;
  logic       in_gnt;
  logic       owner_cyc;
  logic       other_cyc;
  logic       hold_hit;
  logic       preempt;

  // Arbitration decision shared by IDLE, release and the gap fallback.
  always_comb begin
    pick_state = IDLE;
    if (m0_cyc_i && m1_cyc_i) begin
`ifdef WSHB_ARB_RR_EN
      pick_state = last_m1_q ? GNT0 : GNT1;
`else
      pick_state = GNT0;
`endif
    end else if (m0_cyc_i) begin
      pick_state = GNT0;
    end else if (m1_cyc_i) begin
      pick_state = GNT1;
    end
  end

  always_comb begin
    in_gnt    = (state_q == GNT0) || (state_q == GNT1);
    owner_cyc = 1'b0;
    other_cyc = 1'b0;
    if (state_q == GNT0) begin
      owner_cyc = m0_cyc_i;
      other_cyc = m1_cyc_i;
    end else if (state_q == GNT1) begin
      owner_cyc = m1_cyc_i;
      other_cyc = m0_cyc_i;
    end
    // The ack that lands on MAX_HOLD-1 brings the count to MAX_HOLD.  A count
    // already saturated also qualifies, so an owner that ran up its budget
    // before the other master arrived yields on its next ack.
    hold_hit = (hold_q == HOLD_MAX) || (hold_q == (HOLD_MAX - HOLD_ONE));
    preempt  = (MAX_HOLD > 0) && in_gnt && s_ack_i && hold_hit && other_cyc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = pick_state;
      GNT0, GNT1: begin
        // Release has priority over preemption: an owner leaving on the same
        // edge gets a direct handover with no gap cycle.
        if (!owner_cyc) begin
          state_d = pick_state;
        end else if (preempt) begin
          state_d = GAP;
        end
      end
      GAP: begin
        // last_m1_q still names the preempted owner; hand over to the other
        // master, or fall back to normal arbitration if it has gone away.
        if (last_m1_q && m0_cyc_i) begin
          state_d = GNT0;
        end else if (!last_m1_q && m1_cyc_i) begin
          state_d = GNT1;
        end else begin
          state_d = pick_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d    = hold_q;
    last_m1_d = last_m1_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (in_gnt && s_ack_i && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end
    if (state_d == GNT0) begin
      last_m1_d = 1'b0;
    end else if (state_d == GNT1) begin
      last_m1_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_m1_q <= 1'b1;  // master 0 wins the first tie after reset
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Grant is forced to zero during reset so nothing leaks to the slave
  // before the state register has been cleared.
  assign grant_o = rst_i ? GNT_NONE : state_to_grant(state_q);

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter in front of the SDRAM
// controller.  Master 0 is the video frame reader, master 1 a frame-buffer
// writer.  The grant FSM lives in wshb_arb_fsm; this level only steers the
// slave-side and master-side signals according to the one-hot grant.
//
// Ports:
//   clk, rst                  Wishbone clock, synchronous active-high reset
//   m0_* / m1_*               master request buses (cyc, stb, we, adr,
//                             dat_ms, sel, cti, bte) and returns (ack, dat_sm)
//   s_*                       slave request bus and returns (ack, dat_sm)
//   grant                     one-hot owner (bit0 = m0, bit1 = m1), 00 = idle
//
// Parameters: ADR_W, DAT_W (SEL width DAT_W/8), MAX_HOLD (0 = no preemption).
// Build macro: WSHB_ARB_RR_EN selects round-robin tie breaking.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int ADR_W    = 32,
  parameter int DAT_W    = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic                clk,
  input  logic                rst,
  // master 0: video reader
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADR_W-1:0]    m0_adr,
  input  logic [DAT_W-1:0]    m0_dat_ms,
  input  logic [DAT_W/8-1:0]  m0_sel,
  input  logic [CTI_W-1:0]    m0_cti,
  input  logic [BTE_W-1:0]    m0_bte,
  output logic                m0_ack,
  output logic [DAT_W-1:0]    m0_dat_sm,
  // master 1: frame-buffer writer
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADR_W-1:0]    m1_adr,
  input  logic [DAT_W-1:0]    m1_dat_ms,
  input  logic [DAT_W/8-1:0]  m1_sel,
  input  logic [CTI_W-1:0]    m1_cti,
  input  logic [BTE_W-1:0]    m1_bte,
  output logic                m1_ack,
  output logic [DAT_W-1:0]    m1_dat_sm,
  // slave: SDRAM controller
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADR_W-1:0]    s_adr,
  output logic [DAT_W-1:0]    s_dat_ms,
  output logic [DAT_W/8-1:0]  s_sel,
  output logic [CTI_W-1:0]    s_cti,
  output logic [BTE_W-1:0]    s_bte,
  input  logic                s_ack,
  input  logic [DAT_W-1:0]    s_dat_sm,
  // current owner
  output logic [1:0]          grant
);

  logic [1:0] grant_w;

  wshb_arb_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_fsm (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_cyc_i (m0_cyc),
    .m1_cyc_i (m1_cyc),
    .s_ack_i  (s_ack),
    .grant_o  (grant_w)
  );

  assign grant = grant_w;

  // Slave-side request mux.  Everything is zero with no owner, which is what
  // keeps s_cyc low through IDLE and the one-cycle preemption gap.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    case (grant_w)
      GNT_M0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
      end
      GNT_M1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
      end
      default: ;
    endcase
  end

  // Only the owner sees ack, so a preempted master simply stalls.  Read data
  // is broadcast to both masters whenever someone owns the bus.
  assign m0_ack    = grant_w[0] & s_ack;
  assign m1_ack    = grant_w[1] & s_ack;
  assign m0_dat_sm = (grant_w != GNT_NONE) ? s_dat_sm : '0;
  assign m1_dat_sm = (grant_w != GNT_NONE) ? s_dat_sm : '0;

endmodule

// File: tb/tb_wshb_arbiter.sv
module tb_wshb_arbiter;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_cyc, m0_stb, m0_we, m0_ack;
  logic [ADR_W-1:0]  m0_adr;
  logic [DAT_W-1:0]  m0_dat_ms, m0_dat_sm;
  logic [3:0]        m0_sel;
  logic [2:0]        m0_cti;
  logic [1:0]        m0_bte;
  logic              m1_cyc, m1_stb, m1_we, m1_ack;
  logic [ADR_W-1:0]  m1_adr;
  logic [DAT_W-1:0]  m1_dat_ms, m1_dat_sm;
  logic [3:0]        m1_sel;
  logic [2:0]        m1_cti;
  logic [1:0]        m1_bte;
  logic              s_cyc, s_stb, s_we, s_ack;
  logic [ADR_W-1:0]  s_adr;
  logic [DAT_W-1:0]  s_dat_ms, s_dat_sm;
  logic [3:0]        s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic [1:0]        grant;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(
    .ADR_W    (ADR_W),
    .DAT_W    (DAT_W),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_dat_ms (m0_dat_ms),
    .m0_sel    (m0_sel),
    .m0_cti    (m0_cti),
    .m0_bte    (m0_bte),
    .m0_ack    (m0_ack),
    .m0_dat_sm (m0_dat_sm),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_dat_ms (m1_dat_ms),
    .m1_sel    (m1_sel),
    .m1_cti    (m1_cti),
    .m1_bte    (m1_bte),
    .m1_ack    (m1_ack),
    .m1_dat_sm (m1_dat_sm),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_cti     (s_cti),
    .s_bte     (s_bte),
    .s_ack     (s_ack),
    .s_dat_sm  (s_dat_sm),
    .grant     (grant)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later,
  // well away from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [1:0] tie_exp [3];

  initial begin
`ifdef WSHB_ARB_RR_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
`endif
    rst       = 1'b1;
    m0_cyc    = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    m0_adr    = 32'h1000_0040; m0_dat_ms = 32'hAAAA_0000;
    m0_sel    = 4'hF; m0_cti = 3'b010; m0_bte = 2'b01;
    m1_cyc    = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr    = 32'h2000_0000; m1_dat_ms = 32'h5555_1111;
    m1_sel    = 4'h3; m1_cti = 3'b111; m1_bte = 2'b10;
    s_ack     = 1'b1; s_dat_sm = 32'hCAFE_0001;

    // Reset held 3 cycles with both masters requesting and the slave acking.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check_vec("rst_grant", grant, 2'b00);
      check_vec("rst_s_cyc", s_cyc, 1'b0);
      check_vec("rst_m0_ack", m0_ack, 1'b0);
      check_vec("rst_m1_ack", m1_ack, 1'b0);
    end
    next_cycle(); rst = 1'b0; #1;
    check_vec("rel_grant_idle", grant, 2'b00);
    next_cycle(); #1;
    check_vec("rel_grant_m0", grant, 2'b01);
    check_vec("rel_s_cyc", s_cyc, 1'b1);
    check_vec("rel_s_adr", s_adr, 32'h1000_0040);
    check_vec("rel_s_sel", s_sel, 4'hF);
    check_vec("rel_s_cti", s_cti, 3'b010);
    check_vec("rel_m0_ack", m0_ack, 1'b1);
    check_vec("rel_m1_ack", m1_ack, 1'b0);
    check_vec("rel_m0_dat", m0_dat_sm, 32'hCAFE_0001);
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; #1;
    check_vec("drop_s_cyc", s_cyc, 1'b0);
    next_cycle(); s_ack = 1'b1; #1;
    check_vec("idle_grant", grant, 2'b00);
    check_vec("idle_m0_ack", m0_ack, 1'b0);
    check_vec("idle_m1_ack", m1_ack, 1'b0);
    check_vec("idle_m1_dat", m1_dat_sm, 32'h0);

    // Single master: m1 reads 10 words, slave acks every cycle, m0 quiet.
    s_ack = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    next_cycle(); #1;
    check_vec("sm_grant", grant, 2'b10);
    for (int i = 0; i < 10; i++) begin
      m1_adr = 32'h2000_0000 + 32'(i * 4);
      s_ack = 1'b1; s_dat_sm = 32'hD000_0000 + 32'(i);
      #1;
      check_vec("sm_s_adr", s_adr, 32'h2000_0000 + 64'(i * 4));
      check_vec("sm_m1_ack", m1_ack, 1'b1);
      check_vec("sm_m0_ack", m0_ack, 1'b0);
      check_vec("sm_bcast", m0_dat_sm, 32'hD000_0000 + 64'(i));
      next_cycle();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; #1;
    check_vec("sm_grant_hold", grant, 2'b10);
    next_cycle(); #1;
    check_vec("sm_grant_idle", grant, 2'b00);

    // Three ties from IDLE.
    for (int k = 0; k < 3; k++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      next_cycle(); #1;
      check_vec("tie_grant", grant, 64'(tie_exp[k]));
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      next_cycle(); #1;
      check_vec("tie_idle", grant, 2'b00);
    end

    // Direct handover m0 -> m1.
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle(); #1;
    check_vec("ho_m0", grant, 2'b01);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h2000_0100;
    next_cycle(); #1;
    check_vec("ho_m0_keep", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle(); #1;
    check_vec("ho_m1", grant, 2'b10);
    check_vec("ho_s_we", s_we, 1'b1);
    check_vec("ho_s_adr", s_adr, 32'h2000_0100);
    check_vec("ho_s_dat", s_dat_ms, 32'h5555_1111);
    check_vec("ho_s_sel", s_sel, 4'h3);
    check_vec("ho_s_cti", s_cti, 3'b111);
    check_vec("ho_s_bte", s_bte, 2'b10);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle(); #1;
    check_vec("ho_idle", grant, 2'b00);

    // Preemption with MAX_HOLD=4.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle(); #1;
    check_vec("pre_m1", grant, 2'b10);
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    for (int a = 0; a < 4; a++) begin
      #1;
      check_vec("pre_ack_m1", m1_ack, 1'b1);
      check_vec("pre_ack_m0", m0_ack, 1'b0);
      check_vec("pre_ack_grant", grant, 2'b10);
      next_cycle();
    end
    #1;
    check_vec("gap_grant", grant, 2'b00);
    check_vec("gap_s_cyc", s_cyc, 1'b0);
    check_vec("gap_s_stb", s_stb, 1'b0);
    check_vec("gap_m1_ack", m1_ack, 1'b0);
    check_vec("gap_m0_ack", m0_ack, 1'b0);
    next_cycle(); #1;
    check_vec("post_gap_grant", grant, 2'b01);
    check_vec("post_gap_m0_ack", m0_ack, 1'b1);
    check_vec("post_gap_m1_ack", m1_ack, 1'b0);
    check_vec("post_gap_s_adr", s_adr, 32'h1000_0040);
    next_cycle(); #1;
    check_vec("m0_own_m1_ack", m1_ack, 1'b0);
    check_vec("m0_own_grant", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    next_cycle(); #1;
    check_vec("regrant_m1", grant, 2'b10);
    check_vec("regrant_s_stb", s_stb, 1'b1);

    // Reset in the middle of m1's transfer.
    rst = 1'b1; #1;
    check_vec("rst_mid_s_cyc", s_cyc, 1'b0);
    next_cycle(); #1;
    check_vec("rst_mid_grant", grant, 2'b00);
    check_vec("rst_mid_s_stb", s_stb, 1'b0);
    rst = 1'b0;
    next_cycle(); #1;
    check_vec("rst_mid_regrant", grant, 2'b10);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
